// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, access size codes, error codes and controller states
// for the unified 128-byte memory.
package mem_map_pkg;

  localparam int MEM_VECTOR_SIZE    = 128;
  localparam int I_MEM_SIZE         = 32;
  localparam int MEM_MAP_IO_ADDRESS = 127;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_IMEM_WR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_check.sv
// Combinational request validation and effective memory size selection.
// Alignment errors are raised only when ALIGN_CHECK_EN is defined.
module mem_req_check
  import mem_map_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] i_addr,
  input  logic [1:0]           i_size,
  input  logic                 i_we,
  input  logic                 i_sz_ex,
  output logic                 o_err,
  output logic [1:0]           o_err_code,
  output logic [1:0]           o_mem_size,
  output logic                 o_mem_sz_ex
);

  logic w_is_io;
  logic w_in_imem;
  logic w_out_range;

  assign w_is_io     = (i_addr == BUS_WIDTH'(MEM_MAP_IO_ADDRESS));
  assign w_in_imem   = (i_addr < BUS_WIDTH'(I_MEM_SIZE));
  assign w_out_range = (i_addr >= BUS_WIDTH'(MEM_VECTOR_SIZE));

`ifdef ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = !w_is_io &&
                      (((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00)) ||
                       ((i_size == SZ_HALF) && i_addr[0]));
`endif

  always_comb begin
    o_err_code = ERR_OK;
    if (w_out_range)
      o_err_code = ERR_RANGE;
    else if (i_size == SZ_ILL)
      o_err_code = ERR_ALIGN;
`ifdef ALIGN_CHECK_EN
    else if (w_misalign)
      o_err_code = ERR_ALIGN;
`endif
    else if (i_we && w_in_imem)
      o_err_code = ERR_IMEM_WR;
  end

  assign o_err = (o_err_code != ERR_OK);

  // IO word and instruction fetch-space loads are always full-word transfers.
  always_comb begin
    o_mem_size  = i_size;
    o_mem_sz_ex = i_sz_ex;
    if (w_is_io || (!i_we && w_in_imem)) begin
      o_mem_size  = SZ_WORD;
      o_mem_sz_ex = 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: validates one request, drives the memory bus for a fixed
// latency window, then pulses cpu_done. Build option: ALIGN_CHECK_EN (see mem_req_check).
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int BUS_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [BUS_WIDTH-1:0] cpu_addr,
  input  logic [BUS_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]           cpu_size,
  input  logic                 cpu_sz_ex,
  output logic                 cpu_busy,
  output logic                 cpu_done,
  output logic [BUS_WIDTH-1:0] cpu_rdata,
  output logic                 cpu_err,
  output logic [1:0]           cpu_err_code,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_in_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_out_data
);
  import mem_map_pkg::*;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_chk;
  logic                 r_we;
  logic [BUS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0] r_wdata;
  logic [1:0]           r_size;
  logic                 r_sz_ex;

  logic                 w_err;
  logic [1:0]           w_err_code;
  logic [1:0]           w_mem_size;
  logic                 w_mem_sz_ex;

  mem_req_check #(.BUS_WIDTH(BUS_WIDTH)) u_check (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_we        (r_we),
    .i_sz_ex     (r_sz_ex),
    .o_err       (w_err),
    .o_err_code  (w_err_code),
    .o_mem_size  (w_mem_size),
    .o_mem_sz_ex (w_mem_sz_ex)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_chk        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= SZ_WORD;
      r_sz_ex      <= 1'b0;
      cpu_busy     <= 1'b0;
      cpu_done     <= 1'b0;
      cpu_rdata    <= '0;
      cpu_err      <= 1'b0;
      cpu_err_code <= ERR_OK;
      mem_wr_en    <= 1'b0;
      mem_address  <= '0;
      mem_in_data  <= '0;
      mem_size     <= SZ_WORD;
      mem_sz_ex    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we     <= cpu_we;
            r_addr   <= cpu_addr;
            r_wdata  <= cpu_wdata;
            r_size   <= cpu_size;
            r_sz_ex  <= cpu_sz_ex;
            r_chk    <= 1'b1;
            r_cnt    <= 4'(MEM_LATENCY - 1);
            cpu_busy <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // First ISSUE cycle judges the latched request; the bus is driven only if it passes.
          if (r_chk) begin
            r_chk <= 1'b0;
            if (w_err) begin
              cpu_done     <= 1'b1;
              cpu_err      <= 1'b1;
              cpu_err_code <= w_err_code;
              r_state      <= S_ERR;
            end else begin
              mem_address <= r_addr;
              mem_in_data <= r_wdata;
              mem_size    <= w_mem_size;
              mem_sz_ex   <= w_mem_sz_ex;
              mem_wr_en   <= r_we;
            end
          end else if (r_cnt == 4'd0) begin
            mem_wr_en <= 1'b0;
            r_state   <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          if (!r_we)
            cpu_rdata <= mem_out_data;
          cpu_done     <= 1'b1;
          cpu_err      <= 1'b0;
          cpu_err_code <= ERR_OK;
          r_state      <= S_DONE;
        end
        S_DONE, S_ERR: begin
          cpu_done     <= 1'b0;
          cpu_err      <= 1'b0;
          cpu_err_code <= ERR_OK;
          cpu_busy     <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random requests against
// a rule-level reference model and a latency-accurate memory model.
module tb_mem_access_ctrl;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [1:0]  cpu_size = 2'b10;
  logic        cpu_sz_ex = 1'b0;
  logic        cpu_busy, cpu_done, cpu_err, mem_wr_en, mem_sz_ex;
  logic [31:0] cpu_rdata, mem_address, mem_in_data, mem_out_data;
  logic [1:0]  cpu_err_code, mem_size;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata = '0;

  mem_access_ctrl #(.MEM_LATENCY(L), .BUS_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_sz_ex(cpu_sz_ex),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cpu_err_code(cpu_err_code), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_in_data(mem_in_data), .mem_size(mem_size), .mem_sz_ex(mem_sz_ex),
    .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;

  // Memory model: byte array plus IO word, read data delayed by L clock edges.
  logic [7:0]  mem [0:127];
  logic [31:0] io_word;
  logic [31:0] pipe [0:15];

  function automatic logic [31:0] memread(input logic [6:0] a, input logic [1:0] sz, input logic sx);
    logic [7:0] b0, b1, b2, b3;
    if (a == 7'd127) return io_word;
    b0 = mem[a]; b1 = mem[7'(a + 7'd1)]; b2 = mem[7'(a + 7'd2)]; b3 = mem[7'(a + 7'd3)];
    case (sz)
      2'b00:   return sx ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'b01:   return sx ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i * 7 + 3);
      io_word <= 32'h0;
      for (int i = 0; i < 16; i++) pipe[i] <= 32'h0;
    end else begin
      if (mem_wr_en) begin
        if (mem_address[6:0] == 7'd127) io_word <= mem_in_data;
        else for (int i = 0; i < ((mem_size == 2'b00) ? 1 : (mem_size == 2'b01) ? 2 : 4); i++)
          mem[7'(mem_address[6:0] + 7'(i))] <= mem_in_data[8*i +: 8];
      end
      pipe[0] <= memread(mem_address[6:0], mem_size, mem_sz_ex);
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_out_data = pipe[L-1];

  // Reference rules: error code and the size/sign-extend that should reach memory.
  task automatic ref_model(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic sx,
                           output logic [1:0] code, output logic [1:0] esz, output logic esx);
    bit misal;
    misal = (a != 127) && ((sz == 2'b10 && (a % 4) != 0) || (sz == 2'b01 && (a % 2) != 0));
`ifndef ALIGN_CHECK_EN
    misal = 1'b0;
`endif
    if (a >= 128)            code = 2'b01;
    else if (sz == 2'b11)    code = 2'b10;
    else if (misal)          code = 2'b10;
    else if (we && a < 32)   code = 2'b11;
    else                     code = 2'b00;
    if (a == 127 || (!we && a < 32)) begin esz = 2'b10; esx = 1'b0; end
    else begin esz = sz; esx = sx; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first IDLE cycle after completion.
  task automatic do_req(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sx, input bit poke);
    logic [1:0] code, esz;
    logic esx;
    bit good;
    int n, done_n, wr_cycles;
    ref_model(we, a, sz, sx, code, esz, esx);
    good = (code == 2'b00);
    if (good && !we) exp_rdata = memread(a[6:0], esz, esx);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_size = sz; cpu_sz_ex = sx;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    chk({tag, ".busy"}, {31'd0, cpu_busy}, 32'd1);
    done_n = -1; wr_cycles = 0; n = 0;
    while (done_n < 0 && n < 40) begin
      @(negedge clk);
      n++;
      cpu_req = poke && (n == 1);
      if (mem_wr_en) wr_cycles++;
      if (good && n <= L) begin
        chk({tag, ".wr_en"}, {31'd0, mem_wr_en}, {31'd0, we});
        chk({tag, ".maddr"}, mem_address, a);
        chk({tag, ".msize"}, {30'd0, mem_size}, {30'd0, esz});
        chk({tag, ".msx"}, {31'd0, mem_sz_ex}, {31'd0, esx});
        if (we) chk({tag, ".mdata"}, mem_in_data, wd);
      end
      if (cpu_done) done_n = n;
    end
    cpu_req = 1'b0;
    chk({tag, ".latency"}, done_n, good ? L + 2 : 1);
    chk({tag, ".err"}, {31'd0, cpu_err}, {31'd0, !good});
    chk({tag, ".code"}, {30'd0, cpu_err_code}, {30'd0, code});
    chk({tag, ".rdata"}, cpu_rdata, exp_rdata);
    chk({tag, ".wr_cycles"}, wr_cycles, (good && we) ? L : 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, cpu_done}, 32'd0);
    chk({tag, ".idle"}, {31'd0, cpu_busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, {31'd0, cpu_busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, cpu_done}, 32'd0);
    chk({tag, ".rdata"}, cpu_rdata, 32'd0);
    chk({tag, ".err"}, {31'd0, cpu_err}, 32'd0);
    chk({tag, ".code"}, {30'd0, cpu_err_code}, 32'd0);
    chk({tag, ".wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    chk({tag, ".maddr"}, mem_address, 32'd0);
    chk({tag, ".mdata"}, mem_in_data, 32'd0);
    chk({tag, ".msize"}, {30'd0, mem_size}, 32'd2);
    chk({tag, ".msx"}, {31'd0, mem_sz_ex}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    @(negedge clk);

    do_req("st_w40", 1'b1, 32'd40, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
    do_req("ld_w40", 1'b0, 32'd40, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("ld_w40.const", cpu_rdata, 32'hDEADBEEF);
    do_req("st_b33", 1'b1, 32'd33, 32'h000000A5, 2'b00, 1'b0, 1'b0);
    chk("st_b33.rdata_kept", cpu_rdata, 32'hDEADBEEF);
    do_req("ld_b33", 1'b0, 32'd33, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("ld_b33.const", cpu_rdata, 32'hFFFFFFA5);
    do_req("st_imem", 1'b1, 32'd4, 32'h11111111, 2'b10, 1'b0, 1'b0);
    do_req("ld_200", 1'b0, 32'd200, 32'h0, 2'b10, 1'b0, 1'b0);
    do_req("ld_w42", 1'b0, 32'd42, 32'h0, 2'b10, 1'b0, 1'b0);
    do_req("ld_ill", 1'b0, 32'd48, 32'h0, 2'b11, 1'b0, 1'b0);
    do_req("st_h127", 1'b1, 32'd127, 32'h1234ABCD, 2'b01, 1'b0, 1'b0);
    do_req("ld_127", 1'b0, 32'd127, 32'h0, 2'b00, 1'b1, 1'b0);
    chk("ld_127.const", cpu_rdata, 32'h1234ABCD);
    do_req("ld_imem", 1'b0, 32'd5, 32'h0, 2'b00, 1'b1, 1'b0);
    do_req("ld_poke", 1'b0, 32'd40, 32'h0, 2'b10, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("poke.no_extra_done", {31'd0, cpu_done}, 32'd0);
    end

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd40; cpu_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_rst.in_flight", {31'd0, cpu_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    exp_rdata = 32'h0;
    repeat (5) begin
      @(negedge clk);
      chk("mid_rst.no_done", {31'd0, cpu_done}, 32'd0);
    end
    do_req("after_rst", 1'b0, 32'd64, 32'h0, 2'b10, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300)) : 32'($urandom_range(0, 127));
      do_req("rand", 1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the multi-cycle core's unified memory, which has 128 bytes, a registered read path and a memory-mapped IO word. It accepts one load/store request at a time from the datapath and validates address, size and alignment. It drives the memory bus for a fixed latency window, then returns read data or an error with a single-cycle done pulse. Instances sit between the multi-cycle control FSM and the memory block.

Parameters:
MEM_LATENCY, 2, memory clock edges from bus drive to valid mem_out_data (1..15)
BUS_WIDTH, 32, data/address width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cpu_req  input  1  request strobe, sampled only in IDLE
cpu_we  input  1  1=store, 0=load
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data
cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
cpu_sz_ex  input  1  sign-extend load
cpu_busy  output  1  high in every state except IDLE
cpu_done  output  1  one-cycle completion pulse
cpu_rdata  output  32  load result, held until next completion
cpu_err  output  1  valid with cpu_done
cpu_err_code  output  2  00 ok, 01 out-of-range, 10 size/alignment, 11 store to instruction memory
mem_wr_en  output  1  memory write enable
mem_address  output  32  memory address
mem_in_data  output  32  memory write data
mem_size  output  2  memory access size
mem_sz_ex  output  1  memory sign-extend
mem_out_data  input  32  memory read data

Behaviour:
- Reset values: cpu_busy 0, cpu_done 0, cpu_rdata 0, cpu_err 0, cpu_err_code 00, mem_wr_en 0, mem_address 0, mem_in_data 0, mem_size 10, mem_sz_ex 0; state IDLE; latency counter 0.
- Address map: instruction region 0..31, data region 32..126, IO at 127, out of range at 128 and above.
- States: IDLE, ISSUE, CAPTURE, DONE, ERR.
- IDLE: the request is latched at the edge k where cpu_req=1. The check runs on the latched values, in priority order:
  - addr >= 128 gives 01.
  - size 11 gives 10.
  - Misalignment gives 10: word with addr[1:0]!=0, or half with addr[0]!=0.
  - A store with addr < 32 gives 11.
  - Any failure goes to ERR. Otherwise the block goes to ISSUE and the counter loads MEM_LATENCY-1.
- IO address 127 is exempt from the alignment check. It is always issued with mem_size forced to 10 and mem_sz_ex 0.
- Instruction-region loads are issued with mem_size 10 regardless of cpu_size.
- ISSUE: mem_address, mem_in_data, mem_size and mem_sz_ex are held stable for MEM_LATENCY cycles. mem_wr_en equals the latched we for the whole window. The counter decrements, and at 0 the block goes to CAPTURE.
- CAPTURE: mem_wr_en is deasserted. A load registers cpu_rdata <= mem_out_data. A store leaves cpu_rdata unchanged. Next state is DONE.
- DONE: cpu_done=1 and cpu_err=0 for one cycle, then IDLE.
- ERR: cpu_done=1, cpu_err=1 and the code is valid for one cycle, then IDLE. The memory bus is never driven on an error; mem_wr_en stays 0.
- Latency: a good access asserts done in the cycle after edge k+MEM_LATENCY+2. An error asserts done in the cycle after edge k+1.
- cpu_req while busy is ignored, not queued. cpu_req in the DONE cycle is also ignored.
- Back-to-back: a request sampled in the first IDLE cycle after DONE is accepted.
- Reset mid-operation: the block returns to IDLE at that edge and all outputs take reset values. An in-flight store may or may not have been written; no done pulse is produced.

Optional Feature:
ALIGN_CHECK_EN: when defined, the misalignment check above applies (error code 10). When undefined, misaligned half/word accesses are issued unchanged to memory and no alignment error is raised. Size 11 still gives 10 either way.

Decomposition:
- Shared package mem_map_pkg holds:
  - MEM_VECTOR_SIZE=128, I_MEM_SIZE=32, MEM_MAP_IO_ADDRESS=127.
  - Size codes BYTE/HALF/WORD.
  - Error code constants.
  - The state enum.
- One combinational sub-module, mem_req_check, takes addr, size and we and returns err and err_code plus the effective mem_size/sz_ex. The FSM and latency counter stay in mem_access_ctrl.

Test Plan:
- Word load at addr 40 with mem model returning 32'hDEADBEEF after 2 edges -> cpu_done in the cycle after edge k+4, cpu_rdata=DEADBEEF, err 0, mem_wr_en 0 throughout.
- Byte store of 8'hA5 at addr 33 -> mem_wr_en=1 for exactly 2 cycles with mem_size 00 and mem_address 33. Then done with err 0 and cpu_rdata unchanged.
- Store to addr 4 -> done one cycle after the request with err code 11. Load at addr 200 gives code 01. mem_wr_en never asserts.
- Word load at addr 42 -> with ALIGN_CHECK_EN, err code 10. Without it, the access is issued with err 0.
- Half store at 127 -> issued with mem_size 10 and no error. A following load at 127 returns the stored word.
- rst asserted during ISSUE -> next cycle all outputs are at reset values, no done pulse, and the next request completes normally. A cpu_req raised while busy produces no extra done.
